// File: rtl/reu_pkg.sv
// Shared definitions for the REU register file: register offsets, transfer types
// and bit positions inside the status, command, mask and address-control registers.
package reu_pkg;

  localparam logic [4:0] REG_STATUS  = 5'h00;
  localparam logic [4:0] REG_COMMAND = 5'h01;
  localparam logic [4:0] REG_CA_LO   = 5'h02;
  localparam logic [4:0] REG_CA_HI   = 5'h03;
  localparam logic [4:0] REG_REUA_LO = 5'h04;
  localparam logic [4:0] REG_REUA_HI = 5'h05;
  localparam logic [4:0] REG_BANK    = 5'h06;
  localparam logic [4:0] REG_LEN_LO  = 5'h07;
  localparam logic [4:0] REG_LEN_HI  = 5'h08;
  localparam logic [4:0] REG_IMASK   = 5'h09;
  localparam logic [4:0] REG_ACTRL   = 5'h0A;

  typedef enum logic [1:0] {
    XFER_C64REU = 2'd0,
    XFER_REUC64 = 2'd1,
    XFER_SWAP   = 2'd2,
    XFER_VERIFY = 2'd3
  } xfer_e;

  localparam int unsigned ST_IRQ   = 7;
  localparam int unsigned ST_EOB   = 6;
  localparam int unsigned ST_FAULT = 5;
  localparam int unsigned ST_SIZE  = 4;

  localparam int unsigned CMD_EXEC     = 7;
  localparam int unsigned CMD_AUTOLOAD = 5;
  localparam int unsigned CMD_NFF00    = 4;

  // Mask and address-control fields are stored packed from bit 0 upwards.
  localparam int unsigned IM_IE   = 2;
  localparam int unsigned IM_EOBE = 1;
  localparam int unsigned IM_VERE = 0;

  localparam int unsigned AC_FIXC64 = 1;
  localparam int unsigned AC_FIXREU = 0;

endpackage

// File: rtl/reu_shadow_counter.sv
// Working register plus autoload shadow: byte-lane CPU load writes both copies,
// step increments or decrements the working copy, reload copies shadow to working.
module reu_shadow_counter #(
  parameter int unsigned   W         = 16,
  parameter bit            DEC       = 1'b0,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [(W+7)/8-1:0]   lane_we,
  input  logic [7:0]           wdata,
  input  logic                 step,
  input  logic                 reload,
  output logic [W-1:0]         value
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] work_q, work_d, shadow_q, shadow_d;

  always_comb begin
    work_d   = work_q;
    shadow_d = shadow_q;
    if (reload) begin
      work_d = shadow_q;
    end else begin
      for (int unsigned b = 0; b < W; b++) begin
        if (lane_we[b/8]) begin
          work_d[b]   = wdata[b%8];
          shadow_d[b] = wdata[b%8];
        end
      end
      if (step) work_d = DEC ? work_q - ONE : work_q + ONE;
    end
  end

  // State follows the C64 bus: updates on the falling edge of PHI2.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= RESET_VAL;
      shadow_q <= RESET_VAL;
    end else begin
      work_q   <= work_d;
      shadow_q <= shadow_d;
    end
  end

  assign value = work_q;

endmodule

// File: rtl/reu_regs.sv
// REU register file at $DF00-$DF1F: CPU-visible registers, execute arming,
// DMA address/length counters with autoload, and status/interrupt generation.
module reu_regs
  import reu_pkg::*;
#(
  parameter int unsigned REU_ABITS = 19
) (
  input  logic                 PHI2,
  input  logic                 nRESET,
  input  logic                 nIO2,
  input  logic                 RW,
  input  logic [4:0]           A,
  input  logic [7:0]           Din,
  output logic [7:0]           Dout,
  output logic                 DOE,
  input  logic                 FF00Wr,
  input  logic                 DMA,
  input  logic                 IncCA,
  input  logic                 DecLen,
  input  logic                 IncREUA,
  input  logic                 XferEnd,
  input  logic                 SetEndOfBlock,
  input  logic                 SetVerifyErr,
  output logic                 Execute,
  output logic [1:0]           XferType,
  output logic                 Length1,
  output logic                 Length2,
  output logic [15:0]          CA,
  output logic [REU_ABITS-1:0] REUA,
  output logic                 nIRQ
);

  localparam int unsigned PAD      = 24 - REU_ABITS;
  localparam logic        SIZE_BIT = (REU_ABITS > 17);

  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  imask_q, imask_d;
  logic [1:0]  actrl_q, actrl_d;
  logic        eob_q, eob_d, fault_q, fault_d, irq_q, irq_d, exec_q, exec_d;
  logic        wr, rd, reload;
  logic [15:0] len;
  logic [23:0] reua_ext;

  assign wr     = !nIO2 && !RW && !DMA;
  assign rd     = !nIO2 && RW && !DMA;
  assign reload = XferEnd && cmd_q[CMD_AUTOLOAD];

  always_comb begin
    cmd_d   = cmd_q;
    imask_d = imask_q;
    actrl_d = actrl_q;
    eob_d   = eob_q;
    fault_d = fault_q;
    exec_d  = exec_q;
    if (DMA) begin
      exec_d          = 1'b0;
      cmd_d[CMD_EXEC]  = 1'b0;
      cmd_d[CMD_NFF00] = 1'b1;
    end else begin
      // Command bits 6 and 3:2 are kept as plain storage so the register reads back.
      if (wr && A == REG_COMMAND) begin
        cmd_d  = Din;
        exec_d = Din[CMD_EXEC] && Din[CMD_NFF00];
      end else if (FF00Wr && cmd_q[CMD_EXEC] && !cmd_q[CMD_NFF00]) begin
        exec_d = 1'b1;
      end
      if (wr && A == REG_IMASK) imask_d = Din[7:5];
      if (wr && A == REG_ACTRL) actrl_d = Din[7:6];
    end
    if (rd && A == REG_STATUS) begin
      eob_d   = 1'b0;
      fault_d = 1'b0;
    end
    if (SetEndOfBlock) eob_d = 1'b1;
    if (SetVerifyErr) fault_d = 1'b1;
    irq_d = imask_d[IM_IE] &&
            ((imask_d[IM_EOBE] && eob_d) || (imask_d[IM_VERE] && fault_d));
  end

  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      cmd_q   <= 8'h10;
      imask_q <= 3'b000;
      actrl_q <= 2'b00;
      eob_q   <= 1'b0;
      fault_q <= 1'b0;
      irq_q   <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      imask_q <= imask_d;
      actrl_q <= actrl_d;
      eob_q   <= eob_d;
      fault_q <= fault_d;
      irq_q   <= irq_d;
      exec_q  <= exec_d;
    end
  end

  reu_shadow_counter #(.W(16), .DEC(1'b0), .RESET_VAL(16'h0000)) u_ca (
    .clk     (PHI2),
    .rst_n   (nRESET),
    .lane_we ({wr && A == REG_CA_HI, wr && A == REG_CA_LO}),
    .wdata   (Din),
    .step    (IncCA && !actrl_q[AC_FIXC64]),
    .reload  (reload),
    .value   (CA)
  );

  reu_shadow_counter #(.W(REU_ABITS), .DEC(1'b0), .RESET_VAL('0)) u_reua (
    .clk     (PHI2),
    .rst_n   (nRESET),
    .lane_we ({wr && A == REG_BANK, wr && A == REG_REUA_HI, wr && A == REG_REUA_LO}),
    .wdata   (Din),
    .step    (IncREUA && !actrl_q[AC_FIXREU]),
    .reload  (reload),
    .value   (REUA)
  );

  reu_shadow_counter #(.W(16), .DEC(1'b1), .RESET_VAL(16'hFFFF)) u_len (
    .clk     (PHI2),
    .rst_n   (nRESET),
    .lane_we ({wr && A == REG_LEN_HI, wr && A == REG_LEN_LO}),
    .wdata   (Din),
    .step    (DecLen),
    .reload  (reload),
    .value   (len)
  );

  assign reua_ext = {{PAD{1'b1}}, REUA};

  always_comb begin
    Dout = 8'hFF;
    case (A)
      REG_STATUS:  Dout = {irq_q, eob_q, fault_q, SIZE_BIT, 4'b0000};
      REG_COMMAND: Dout = cmd_q;
      REG_CA_LO:   Dout = CA[7:0];
      REG_CA_HI:   Dout = CA[15:8];
      REG_REUA_LO: Dout = reua_ext[7:0];
      REG_REUA_HI: Dout = reua_ext[15:8];
      REG_BANK:    Dout = reua_ext[23:16];
      REG_LEN_LO:  Dout = len[7:0];
      REG_LEN_HI:  Dout = len[15:8];
      REG_IMASK:   Dout = {imask_q, 5'b11111};
      REG_ACTRL:   Dout = {actrl_q, 6'b111111};
      default:     Dout = 8'hFF;
    endcase
  end

  assign DOE      = !nIO2 && RW && !DMA;
  assign Execute  = exec_q;
  assign XferType = cmd_q[1:0];
  assign Length1  = (len == 16'd1);
  assign Length2  = (len == 16'd2);
  assign nIRQ     = !irq_q;

endmodule
